// File: rtl/ds_pkg.sv
// Shared definitions for the 2x2 SRAM neighbourhood reader: size defaults,
// FSM state encoding and a small clamp helper.
package ds_pkg;

    localparam int ADDR_BITS_DEF  = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam int COORD_BITS     = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A0   = 3'd1,
        ST_A1   = 3'd2,
        ST_A2   = 3'd3,
        ST_A3   = 3'd4,
        ST_CAP  = 3'd5,
        ST_OUT  = 3'd6
    } state_e;

    // Corner select: bit 0 picks x1 over x0, bit 1 picks y1 over y0.
    localparam logic [1:0] CORNER_00 = 2'b00;
    localparam logic [1:0] CORNER_01 = 2'b01;
    localparam logic [1:0] CORNER_10 = 2'b10;
    localparam logic [1:0] CORNER_11 = 2'b11;

    function automatic logic [COORD_BITS-1:0] clamp_max(
        input logic [COORD_BITS-1:0] v,
        input logic [COORD_BITS-1:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sram_addr_gen.sv
// Combinational clamp and linear address generator for one corner of the
// 2x2 neighbourhood anchored at (x, y) in a w x h image.
module sram_addr_gen
    import ds_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF
) (
    input  logic [COORD_BITS-1:0] x,
    input  logic [COORD_BITS-1:0] y,
    input  logic [COORD_BITS-1:0] w,
    input  logic [COORD_BITS-1:0] h,
    input  logic [1:0]            sel,
    output logic [ADDR_BITS-1:0]  addr
);

    logic [COORD_BITS-1:0] w_eff;
    logic [COORD_BITS-1:0] h_eff;
    logic [COORD_BITS-1:0] x0;
    logic [COORD_BITS-1:0] y0;
    logic [COORD_BITS-1:0] x1;
    logic [COORD_BITS-1:0] y1;
    logic [COORD_BITS-1:0] cx;
    logic [COORD_BITS-1:0] cy;
    logic [31:0]           lin;

    // Zero-sized dimensions behave as one pixel; x0 <= w_eff-1 so x0+1 never overflows.
    always_comb begin
        w_eff = (w == 16'd0) ? 16'd1 : w;
        h_eff = (h == 16'd0) ? 16'd1 : h;
        x0    = clamp_max(x, w_eff - 16'd1);
        y0    = clamp_max(y, h_eff - 16'd1);
        x1    = clamp_max(x0 + 16'd1, w_eff - 16'd1);
        y1    = clamp_max(y0 + 16'd1, h_eff - 16'd1);
        cx    = sel[0] ? x1 : x0;
        cy    = sel[1] ? y1 : y0;
        lin   = ({16'd0, cy} * {16'd0, w_eff}) + {16'd0, cx};
        addr  = lin[ADDR_BITS-1:0];
    end

endmodule

// File: rtl/sram_quad_reader.sv
// Fetches a clamped 2x2 pixel neighbourhood from a single-port SRAM with a
// one-cycle registered read, then presents it on a valid/ready interface.
module sram_quad_reader
    import ds_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cfg_width,
    input  logic [15:0]           cfg_height,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [15:0]           req_x,
    input  logic [15:0]           req_y,
    output logic                  mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_BITS-1:0]  mem_data_in,
    input  logic [DATA_BITS-1:0]  mem_data_out,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_BITS-1:0]  p00,
    output logic [DATA_BITS-1:0]  p01,
    output logic [DATA_BITS-1:0]  p10,
    output logic [DATA_BITS-1:0]  p11
);

    state_e                 state_q, state_d;
    logic [15:0]            x_q, x_d;
    logic [15:0]            y_q, y_d;
    logic [15:0]            w_q, w_d;
    logic [15:0]            h_q, h_d;
    logic [DATA_BITS-1:0]   p00_q, p00_d;
    logic [DATA_BITS-1:0]   p01_q, p01_d;
    logic [DATA_BITS-1:0]   p10_q, p10_d;
    logic [DATA_BITS-1:0]   p11_q, p11_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]             gen_sel;
    logic                   gen_active;
    logic [ADDR_BITS-1:0]   gen_addr;

    sram_addr_gen #(
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_gen (
        .x    (x_q),
        .y    (y_q),
        .w    (w_q),
        .h    (h_q),
        .sel  (gen_sel),
        .addr (gen_addr)
    );

    // Next-state and request latching.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_A0;
                    x_d     = req_x;
                    y_d     = req_y;
                    w_d     = cfg_width;
                    h_d     = cfg_height;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_A0:   state_d = ST_A1;
            ST_A1:   state_d = ST_A2;
            ST_A2:   state_d = ST_A3;
            ST_A3:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_OUT;
            ST_OUT: begin
                if (pix_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data trails its address by one state, so each pixel lands one state later.
    always_comb begin
        p00_d = p00_q;
        p01_d = p01_q;
        p10_d = p10_q;
        p11_d = p11_q;
        case (state_q)
            ST_A1:   p00_d = mem_data_out;
            ST_A2:   p01_d = mem_data_out;
            ST_A3:   p10_d = mem_data_out;
            ST_CAP:  p11_d = mem_data_out;
            default: p00_d = p00_q;
        endcase
        pix_valid_d = (state_d == ST_OUT);
    end

    // Corner select per address state; outside A0..A3 the bus holds its last value.
    always_comb begin
        gen_sel    = CORNER_00;
        gen_active = 1'b0;
        case (state_q)
            ST_A0: begin gen_sel = CORNER_00; gen_active = 1'b1; end
            ST_A1: begin gen_sel = CORNER_01; gen_active = 1'b1; end
            ST_A2: begin gen_sel = CORNER_10; gen_active = 1'b1; end
            ST_A3: begin gen_sel = CORNER_11; gen_active = 1'b1; end
            default: begin gen_sel = CORNER_00; gen_active = 1'b0; end
        endcase
        mem_addr_d = gen_active ? gen_addr : mem_addr_q;
    end

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            w_q         <= 16'd0;
            h_q         <= 16'd0;
            p00_q       <= {DATA_BITS{1'b0}};
            p01_q       <= {DATA_BITS{1'b0}};
            p10_q       <= {DATA_BITS{1'b0}};
            p11_q       <= {DATA_BITS{1'b0}};
            pix_valid_q <= 1'b0;
            mem_addr_q  <= {ADDR_BITS{1'b0}};
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            p00_q       <= p00_d;
            p01_q       <= p01_d;
            p10_q       <= p10_d;
            p11_q       <= p11_d;
            pix_valid_q <= pix_valid_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign mem_we      = 1'b0;
    assign mem_data_in = {DATA_BITS{1'b0}};
    assign mem_addr    = mem_addr_d;
    assign pix_valid   = pix_valid_q;
    assign p00         = p00_q;
    assign p01         = p01_q;
    assign p10         = p10_q;
    assign p11         = p11_q;

endmodule

// File: tb/tb_sram_quad_reader.sv
// Randomized and directed bench for sram_quad_reader with a behavioural SRAM
// and an arithmetic reference model of the clamped 2x2 address pattern.
module tb_sram_quad_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_width, cfg_height;
    logic        req_valid, req_ready;
    logic [15:0] req_x, req_y;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_in, mem_data_out;
    logic        pix_valid, pix_ready;
    logic [7:0]  p00, p01, p10, p11;

    logic [7:0]  tb_mem [0:65535];
    logic [31:0] obs_addr [4];
    logic [31:0] obs_pix  [4];
    int          n_checks = 0;
    int          n_fail   = 0;

    sram_quad_reader dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .p00          (p00),
        .p01          (p01),
        .p10          (p10),
        .p11          (p11)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_data_in;
        mem_data_out <= tb_mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Image-space rule: clamp into the (at least 1x1) image, then y*W+x mod 2^16.
    function automatic longint unsigned ref_addr(input longint unsigned x, input longint unsigned y,
                                                 input longint unsigned w, input longint unsigned h,
                                                 input int corner);
        longint unsigned ww, hh, x0, y0, x1, y1, cx, cy;
        ww = (w == 0) ? 1 : w;
        hh = (h == 0) ? 1 : h;
        x0 = (x < ww) ? x : ww - 1;
        y0 = (y < hh) ? y : hh - 1;
        x1 = (x0 + 1 < ww) ? x0 + 1 : ww - 1;
        y1 = (y0 + 1 < hh) ? y0 + 1 : hh - 1;
        cx = (corner % 2 == 1) ? x1 : x0;
        cy = (corner >= 2) ? y1 : y0;
        return (cy * ww + cx) % 65536;
    endfunction

    function automatic logic [31:0] pix_of(input int k);
        case (k)
            0: return {24'd0, p00};
            1: return {24'd0, p01};
            2: return {24'd0, p10};
            default: return {24'd0, p11};
        endcase
    endfunction

    task automatic run_req(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] w, input logic [15:0] h, input int hold);
        logic [31:0] exp_a [4];
        int waited = 0;
        for (int k = 0; k < 4; k++) exp_a[k] = 32'(ref_addr(x, y, w, h, k));
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_x = x; req_y = y; cfg_width = w; cfg_height = h;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_x = 16'($urandom); req_y = 16'($urandom);
        cfg_width = 16'($urandom); cfg_height = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            obs_addr[k] = {16'd0, mem_addr};
            check_eq($sformatf("addr_a%0d", k), {16'd0, mem_addr}, exp_a[k]);
            check_eq("pix_valid_low", {31'd0, pix_valid}, 32'd0);
            check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
            check_eq("mem_we", {31'd0, mem_we}, 32'd0);
            @(posedge clk); #1;
        end
        check_eq("pix_valid_cap", {31'd0, pix_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("pix_valid_edge5", {31'd0, pix_valid}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            obs_pix[k] = pix_of(k);
            check_eq($sformatf("pix%0d", k), pix_of(k), {24'd0, tb_mem[exp_a[k][15:0]]});
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", {31'd0, pix_valid}, 32'd1);
            check_eq("hold_ready", {31'd0, req_ready}, 32'd0);
            check_eq("hold_addr", {16'd0, mem_addr}, exp_a[3]);
            check_eq("hold_we", {31'd0, mem_we}, 32'd0);
            for (int k = 0; k < 4; k++)
                check_eq($sformatf("hold_pix%0d", k), pix_of(k), obs_pix[k]);
        end
        pix_ready = 1'b1;
        @(posedge clk); #1;
        pix_ready = 1'b0;
        check_eq("done_valid", {31'd0, pix_valid}, 32'd0);
        check_eq("done_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("done_pix%0d", k), pix_of(k), obs_pix[k]);
    endtask

    task automatic expect_all(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
        logic [31:0] e [4];
        e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("%s_addr%0d", tag, k), obs_addr[k], e[k]);
            check_eq($sformatf("%s_pix%0d", tag, k), obs_pix[k], {24'd0, e[k][7:0]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w, h;
        rst = 1'b1; req_valid = 1'b0; pix_ready = 1'b0;
        req_x = 16'd0; req_y = 16'd0; cfg_width = 16'd0; cfg_height = 16'd0;
        for (int a = 0; a < 65536; a++) tb_mem[a] = 8'(a);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {31'd0, pix_valid}, 32'd0);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_addr", {16'd0, mem_addr}, 32'd0);
        check_eq("rst_p00", {24'd0, p00}, 32'd0);
        check_eq("rst_p11", {24'd0, p11}, 32'd0);
        rst = 1'b0;

        run_req(16'd3, 16'd2, 16'd10, 16'd8, 3);
        expect_all("interior", 32'd23, 32'd24, 32'd33, 32'd34);
        run_req(16'd9, 16'd7, 16'd10, 16'd8, 0);
        expect_all("corner", 32'd79, 32'd79, 32'd79, 32'd79);
        run_req(16'd15, 16'd20, 16'd10, 16'd8, 1);
        expect_all("outside", 32'd79, 32'd79, 32'd79, 32'd79);
        run_req(16'd0, 16'd0, 16'd0, 16'd0, 0);
        expect_all("zero_dim", 32'd0, 32'd0, 32'd0, 32'd0);
        run_req(16'd255, 16'd255, 16'd256, 16'd256, 0);
        check_eq("wrap_max", obs_addr[0], 32'd65535);
        run_req(16'd0, 16'd300, 16'd300, 16'd400, 0);
        check_eq("wrap_mod", obs_addr[0], 32'd24464);

        // Reset while in A2 abandons the request.
        req_valid = 1'b1; req_x = 16'd3; req_y = 16'd2; cfg_width = 16'd10; cfg_height = 16'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mid_p00", {24'd0, p00}, 32'd23);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_mid_valid", {31'd0, pix_valid}, 32'd0);
        check_eq("rst_mid_addr", {16'd0, mem_addr}, 32'd0);
        for (int k = 0; k < 4; k++) check_eq($sformatf("rst_mid_pix%0d", k), pix_of(k), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check_eq("no_pulse", {31'd0, pix_valid}, 32'd0);
        end
        run_req(16'd3, 16'd2, 16'd10, 16'd8, 0);
        expect_all("after_rst", 32'd23, 32'd24, 32'd33, 32'd34);

        for (int a = 0; a < 65536; a++) tb_mem[a] = 8'($urandom);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin w = 16'($urandom_range(0, 3)); h = 16'($urandom_range(0, 3)); end
                1: begin w = 16'($urandom); h = 16'($urandom); end
                default: begin w = 16'($urandom_range(1, 400)); h = 16'($urandom_range(1, 400)); end
            endcase
            run_req(16'($urandom_range(0, 32'(w) + 3)), 16'($urandom_range(0, 32'(h) + 3)),
                    w, h, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
